decoder_range_seq: RTL and testbench
====================================

Name: decoder_range_seq

Overview:
- Parametrised, registered successor to the team's fixed 6-to-40 enable-gated one-hot decoders.
- Turns a start address plus length into register-bank write-enable masks.
- Two modes: mask (whole contiguous range in one beat) and walk (one one-hot bit per beat).
- Valid/ready handshake on both sides; sits between an instruction-issue stage and a banked register file.

Parameters:
ADDR_W, 6, address width
OUT_W, 40, number of decoded outputs (legal: 2..2^ADDR_W)
CNT_W, 3, length field width; lengths 1..2^CNT_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&&in_ready
in_addr  in  ADDR_W  start index
in_len_m1  in  CNT_W  length minus one
in_mode  in  1  0=mask, 1=walk
en  in  1  output gate; 0 forces out_mask to zero
out_valid  out  1  beat valid
out_ready  in  1  beat consumed when out_valid&&out_ready
out_mask  out  OUT_W  decoded mask, gated by en
out_last  out  1  final beat of request
out_err  out  1  beat had an index >= OUT_W

Behaviour:
- Clock/reset: one clock, clk; reset is rst_n, asynchronous, active-low.
- Reset values: state=IDLE; out_valid=0, out_mask reg=0, out_last=0, out_err=0, internal address/counter=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational, 1 after reset.
- Latency: accept in cycle N -> out_valid=1 in cycle N+1.
- Output register holds all values stable while out_valid && !out_ready.
- States: IDLE, WALK.
- IDLE, accept, mode 0: load mask with bits in_addr..in_addr+in_len_m1; out_last=1; remain IDLE.
- IDLE, accept, mode 1: load 1<<in_addr.
  - in_len_m1==0: out_last=1, remain IDLE.
  - otherwise: latch next index = in_addr+1 and remaining = in_len_m1; go WALK; out_last=0.
- WALK, on beat consumed: load one-hot of next index, increment index, decrement remaining.
  - Beat loaded with remaining==1 sets out_last=1 and returns to IDLE.
- IDLE, beat consumed, no accept: out_valid -> 0.
- Index arithmetic: ADDR_W+1 bits, no wrap; indices >= OUT_W are dropped.
- Drop rules:
  - Mask mode: any dropped bit sets out_err for that beat.
  - Walk mode: a beat whose index >= OUT_W emits an all-zero mask with out_err=1 and still counts as a beat.
- in_addr >= OUT_W: all beats zero, out_err=1.
- en: out_mask = en ? reg : 0, purely combinational; handshake, out_last and out_err unaffected.
- Reset asserted mid-walk aborts the request immediately; no resumption after release.
- Simultaneous consume in IDLE and new accept: new beat loads, out_valid stays 1.

Optional Feature:
- Macro: DECODER_RANGE_SEQ_WRAP_EN.
- Defined: indices are taken modulo OUT_W (wrap to bit 0). out_err is set only when in_addr >= OUT_W; that request produces zero masks.
- Undefined: drop/error behaviour as specified above.

Decomposition:
- Shared package decoder_pkg: state encodings (IDLE=0, WALK=1), mode constants MODE_MASK=0 and MODE_WALK=1, default-parameter localparams.
- Sub-module decoder_range_mask (combinational):
  - Inputs: addr, len_m1.
  - Outputs: mask[OUT_W], err.
  - Honours WRAP_EN.
  - Used for mask mode, and with len_m1=0 for walk beats.

Test Plan (OUT_W=40, CNT_W=3, en=1, out_ready=1 unless stated):
1. Mask mode, addr=5, len_m1=3 -> next cycle out_mask=40'h00_0000_01E0, out_last=1, out_err=0; in_ready stays 1.
2. Walk mode, addr=10, len_m1=2 -> three consecutive beats 1<<10, 1<<11, 1<<12; out_last only on the third; in_ready=0 during beats 1-2.
3. Walk mode, addr=0, len_m1=1; out_ready=0 for 3 cycles -> out_mask holds 40'h1 with in_ready=0; then 40'h2 with out_last=1.
4. Mask mode, addr=38, len_m1=3 -> 40'hC0_0000_0000, out_err=1. With WRAP_EN -> 40'hC0_0000_0003, out_err=0. Walk mode, addr=45 -> zero masks, out_err=1 on every beat.
5. en=0 during walk addr=2, len_m1=1 -> out_mask=0 on both beats; handshake and out_last unchanged; en=1 on the second beat -> 40'h8.
6. rst_n low during the second beat of a len_m1=4 walk -> out_valid=0 immediately without a clock edge; after release in_ready=1, state IDLE, no further beats.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and defaults for the range decoder.
// Optional wrap-around of indices is selected with DECODER_RANGE_SEQ_WRAP_EN.
package decoder_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_OUT_W  = 40;
    localparam int DEF_CNT_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    localparam logic MODE_MASK = 1'b0;
    localparam logic MODE_WALK = 1'b1;

endpackage

// File: rtl/decoder_range_mask.sv
// Combinational range decoder: sets bits addr..addr+len_m1, flags dropped indices.
// With DECODER_RANGE_SEQ_WRAP_EN, indices wrap modulo OUT_W and only addr >= OUT_W errors.
module decoder_range_mask
    import decoder_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int IDX_W = DEF_ADDR_W + 1
) (
    input  logic [IDX_W-1:0] addr,
    input  logic [CNT_W-1:0] len_m1,
    output logic [OUT_W-1:0] mask,
    output logic             err
);

    localparam int LEN_N = 1 << CNT_W;

    int pos;

    // NOTE: every output and temporary gets a default first so no latch is inferred.
    always_comb begin
        mask = '0;
        err  = 1'b0;
        pos  = 0;
        for (int i = 0; i < LEN_N; i++) begin
            if (i <= int'(len_m1)) begin
                pos = int'(addr) + i;
`ifdef DECODER_RANGE_SEQ_WRAP_EN
                if (int'(addr) >= OUT_W) begin
                    err = 1'b1;
                end else begin
                    pos = pos % OUT_W;
                    for (int b = 0; b < OUT_W; b++) begin
                        if (pos == b) mask[b] = 1'b1;
                    end
                end
`else
                if (pos >= OUT_W) begin
                    err = 1'b1;
                end else begin
                    for (int b = 0; b < OUT_W; b++) begin
                        if (pos == b) mask[b] = 1'b1;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: rtl/decoder_range_seq.sv
// Registered range/walk decoder producing write-enable masks with valid/ready on both sides.
// Define DECODER_RANGE_SEQ_WRAP_EN to wrap indices modulo OUT_W instead of dropping them.
module decoder_range_seq
    import decoder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [CNT_W-1:0]  in_len_m1,
    input  logic              in_mode,
    input  logic              en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_mask,
    output logic              out_last,
    output logic              out_err
);

    // One spare bit so start + length never wraps inside the index arithmetic.
    localparam int IDX_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;

    state_t             state, state_nxt;
    logic               valid_q, valid_nxt;
    logic [OUT_W-1:0]   mask_q, mask_nxt;
    logic               last_q, last_nxt;
    logic               err_q, err_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic [CNT_W-1:0]   rem_q, rem_nxt;

    logic [IDX_W-1:0]   dec_addr;
    logic [CNT_W-1:0]   dec_len;
    logic [OUT_W-1:0]   dec_mask;
    logic               dec_err;
    logic               accept, consume;

    function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] idx);
`ifdef DECODER_RANGE_SEQ_WRAP_EN
        if (int'(idx) == OUT_W - 1) return '0;
`endif
        return idx + 1'b1;
    endfunction

    assign in_ready = (state == IDLE) && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = valid_q && out_ready;

    // In WALK the decoder sees the latched index; otherwise the incoming request.
    assign dec_addr = (state == WALK) ? idx_q : IDX_W'(in_addr);
    assign dec_len  = (state == WALK || in_mode == MODE_WALK) ? '0 : in_len_m1;

    decoder_range_mask #(
        .OUT_W (OUT_W),
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_mask (
        .addr   (dec_addr),
        .len_m1 (dec_len),
        .mask   (dec_mask),
        .err    (dec_err)
    );

    always_comb begin
        state_nxt = state;
        valid_nxt = valid_q;
        mask_nxt  = mask_q;
        last_nxt  = last_q;
        err_nxt   = err_q;
        idx_nxt   = idx_q;
        rem_nxt   = rem_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    valid_nxt = 1'b1;
                    mask_nxt  = dec_mask;
                    err_nxt   = dec_err;
                    if (in_mode == MODE_MASK || in_len_m1 == '0) begin
                        last_nxt = 1'b1;
                    end else begin
                        last_nxt  = 1'b0;
                        idx_nxt   = step_idx(IDX_W'(in_addr));
                        rem_nxt   = in_len_m1;
                        state_nxt = WALK;
                    end
                end else if (consume) begin
                    valid_nxt = 1'b0;
                end
            end
            WALK: begin
                if (consume) begin
                    mask_nxt = dec_mask;
                    err_nxt  = dec_err;
                    idx_nxt  = step_idx(idx_q);
                    rem_nxt  = rem_q - 1'b1;
                    last_nxt = (rem_q == CNT_W'(1));
                    if (rem_q == CNT_W'(1)) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; every register, including
    // the walk index and counter, is cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            mask_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            rem_q   <= '0;
        end else begin
            state   <= state_nxt;
            valid_q <= valid_nxt;
            mask_q  <= mask_nxt;
            last_q  <= last_nxt;
            err_q   <= err_nxt;
            idx_q   <= idx_nxt;
            rem_q   <= rem_nxt;
        end
    end

    assign out_valid = valid_q;
    assign out_mask  = en ? mask_q : '0;
    assign out_last  = last_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_decoder_range_seq.sv
// Directed self-checking bench for decoder_range_seq (OUT_W=40, CNT_W=3).
// Expected values follow DECODER_RANGE_SEQ_WRAP_EN when the bench is built with it.
module tb_decoder_range_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_addr;
    logic [2:0]  in_len_m1;
    logic        in_mode;
    logic        en;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_mask;
    logic        out_last;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    decoder_range_seq #(.ADDR_W(6), .OUT_W(40), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_len_m1 (in_len_m1),
        .in_mode   (in_mode),
        .en        (en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [39:0] m, input logic l, input logic e,
                        input logic rdy);
        check({tag, " valid"}, 64'(out_valid), 64'd1);
        check({tag, " mask"}, 64'(out_mask), 64'(m));
        check({tag, " last"}, 64'(out_last), 64'(l));
        check({tag, " err"}, 64'(out_err), 64'(e));
        check({tag, " in_ready"}, 64'(in_ready), 64'(rdy));
    endtask

    task automatic send(input logic [5:0] a, input logic [2:0] l, input logic m);
        in_valid  = 1'b1;
        in_addr   = a;
        in_len_m1 = l;
        in_mode   = m;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_len_m1 = '0; in_mode = 1'b0;
        en = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_mask", 64'(out_mask), 64'd0);
        check("rst out_last", 64'(out_last), 64'd0);
        check("rst out_err", 64'(out_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: mask mode range
        send(6'd5, 3'd3, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        beat("t1", 40'h00_0000_01E0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("t1 drain", 64'(out_valid), 64'd0);

        // 2: walk of three beats
        send(6'd10, 3'd2, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        beat("t2 b1", 40'h400, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        beat("t2 b2", 40'h800, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        beat("t2 b3", 40'h1000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("t2 drain", 64'(out_valid), 64'd0);

        // 3: back-pressure holds the first walk beat
        send(6'd0, 3'd1, 1'b1);
        out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat("t3 hold", 40'h1, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        beat("t3 hold", 40'h1, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        beat("t3 b2", 40'h2, 1'b1, 1'b0, 1'b1);
        @(negedge clk);

        // Back-to-back mask requests: consume and accept in the same cycle
        send(6'd0, 3'd0, 1'b0);
        @(negedge clk);
        beat("b2b 1", 40'h1, 1'b1, 1'b0, 1'b1);
        send(6'd39, 3'd0, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        beat("b2b 2", 40'h80_0000_0000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);

        // 4: top-edge range fits exactly, then overruns
        send(6'd36, 3'd3, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        beat("t4 fit", 40'hF0_0000_0000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        send(6'd38, 3'd3, 1'b0);
        @(negedge clk); in_valid = 1'b0;
`ifdef DECODER_RANGE_SEQ_WRAP_EN
        beat("t4 over", 40'hC0_0000_0003, 1'b1, 1'b0, 1'b1);
`else
        beat("t4 over", 40'hC0_0000_0000, 1'b1, 1'b1, 1'b1);
`endif
        @(negedge clk);
        send(6'd45, 3'd2, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        beat("t4 oob b1", 40'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        beat("t4 oob b2", 40'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        beat("t4 oob b3", 40'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);

        // Walk crossing the top edge
        send(6'd39, 3'd1, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        beat("edge b1", 40'h80_0000_0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
`ifdef DECODER_RANGE_SEQ_WRAP_EN
        beat("edge b2", 40'h1, 1'b1, 1'b0, 1'b1);
`else
        beat("edge b2", 40'h0, 1'b1, 1'b1, 1'b1);
`endif
        @(negedge clk);

        // 5: en gates the mask only
        en = 1'b0;
        send(6'd2, 3'd1, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        beat("t5 b1", 40'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        beat("t5 b2", 40'h0, 1'b1, 1'b0, 1'b1);
        en = 1'b1;
        #1;
        check("t5 en mask", 64'(out_mask), 64'h8);
        @(negedge clk);

        // 6: asynchronous reset aborts a walk
        send(6'd20, 3'd4, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        beat("t6 b1", 40'h10_0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        beat("t6 b2", 40'h20_0000, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async valid", 64'(out_valid), 64'd0);
        check("t6 async ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6 no resume", 64'(out_valid), 64'd0);
            check("t6 idle ready", 64'(in_ready), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
